// File: rtl/hs_pkg.sv
// Shared helpers for replay-style handshake blocks.
// Width helper and repeat-count limit.
package hs_pkg;

  localparam int HS_MAX_REPEAT = 65535;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hs_out_slot.sv
// One-entry registered valid stage with load/drain/free strobes.
// Load wins over drain so a slot can be refilled in the cycle it empties.
module hs_out_slot (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_ready,
  output logic o_valid,
  output logic o_drain,
  output logic o_free
);

  logic r_valid;

  assign o_valid = r_valid;
  assign o_drain = r_valid & i_ready;
  assign o_free  = ~r_valid | i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (o_drain) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/handshake_constant_rep.sv
// Elastic constant source: each ctrl token yields REPEAT tokens of VALUE.
// Define HANDSHAKE_CONSTANT_CNT_EN to add the tok_count handshake counter.
module handshake_constant_rep
  import hs_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] VALUE      = 64'd0,
  parameter int          REPEAT     = 1,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  tok_count
`endif
);

  localparam int RW = clog2_min1(REPEAT);
  localparam logic [RW-1:0] REM_INIT = RW'(REPEAT - 1);

  if (REPEAT < 1 || REPEAT > HS_MAX_REPEAT || CNT_WIDTH < 1) begin : g_bad_param
    $error("handshake_constant_rep: REPEAT must be 1..65535");
  end

  logic [RW-1:0] r_rem;
  logic          w_valid;
  logic          w_drain;
  logic          w_free;
  logic          w_accept;
  logic          w_reload;
  logic          w_load;

  assign outs       = DATA_WIDTH'(VALUE);
  assign ctrl_ready = ~rst & (r_rem == '0) & w_free;
  assign outs_valid = w_valid & ~rst;
  assign w_accept   = ctrl_valid & ctrl_ready;
  assign w_reload   = w_drain & (r_rem != '0);
  assign w_load     = w_accept | w_reload;

  hs_out_slot u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_ready (outs_ready),
    .o_valid (w_valid),
    .o_drain (w_drain),
    .o_free  (w_free)
  );

  // rem counts repeats still owed beyond the one sitting in the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
    end else if (w_accept) begin
      r_rem <= REM_INIT;
    end else if (w_reload) begin
      r_rem <= r_rem - RW'(1);
    end
  end

`ifdef HANDSHAKE_CONSTANT_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign tok_count = r_cnt;
`endif

endmodule
